updown_sweep_ctrl: RTL and testbench

Sequencer for an 8-bit up/down counter datapath. It runs a programmed triangle sweep: load `lo`, count up to `hi`, count down to `lo`, and repeat for `cycles` round trips. It then pulses `done` and returns to idle. It sits between the lab control logic (start/abort) and the counter/display path, and owns the counter's load, enable and direction controls.

---
 rtl/sweep_pkg.sv | 18 +
 rtl/udcnt_core.sv | 30 +++
 rtl/updown_sweep_ctrl.sv | 175 +++++++++++++++++
 tb/tb_updown_sweep_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/sweep_pkg.sv
// Shared definitions for the up/down sweep sequencer.
//   sweep_state_t : controller states (IDLE, UP, DOWN, DWELL, DONE)
//   SWEEP_WIDTH   : default counter / bound width
//   SWEEP_CYC_W   : default round-trip count width
package sweep_pkg;

  localparam int unsigned SWEEP_WIDTH = 8;
  localparam int unsigned SWEEP_CYC_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UP,
    S_DOWN,
    S_DWELL,
    S_DONE
  } sweep_state_t;

endpackage

// File: rtl/udcnt_core.sv
// WIDTH-bit up/down counter with synchronous load.
//   clk, rst  : rising-edge clock, async active-high reset (clears to 0)
//   load      : load load_val (priority over en)
//   load_val  : value to load
//   en        : count enable
//   mode      : 0 = increment, 1 = decrement
//   cnt       : counter value
module udcnt_core #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             mode,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_cnt <= '0;
    else if (load) r_cnt <= load_val;
    else if (en)   r_cnt <= mode ? r_cnt - 1'b1 : r_cnt + 1'b1;
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Triangle-sweep sequencer for an up/down counter: load lo, count up to hi,
// back down to lo, repeated for `cycles` round trips, then pulse done.
// Optional feature macro: SWEEP_DWELL_EN (hold DWELL_CYC extra cycles at
// each turning point except the final lo).
//   clk, rst     : rising-edge clock, async active-high reset
//   start, abort : sweep request (IDLE only) / stop request (while busy)
//   lo, hi       : bounds, captured at start
//   cycles       : round-trip count, captured at start
//   cnt, dir     : counter value, direction (1 = counting down)
//   busy         : sweep in progress
//   done, err    : completion pulse / rejected-start pulse
module updown_sweep_ctrl
  import sweep_pkg::*;
#(
  parameter int unsigned WIDTH     = SWEEP_WIDTH,
  parameter int unsigned CYC_W     = SWEEP_CYC_W,
  parameter int unsigned DWELL_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [CYC_W-1:0] cycles,
  output logic [WIDTH-1:0] cnt,
  output logic             dir,
  output logic             busy,
  output logic             done,
  output logic             err
);

  sweep_state_t     r_state, w_next;
  logic [WIDTH-1:0] r_lo, r_hi;
  logic [CYC_W-1:0] r_rem;
  logic             r_dir, r_err;
  logic [WIDTH-1:0] w_cnt;
  logic             w_load, w_en, w_mode, w_cap, w_rej, w_rem_dec, w_dir_nxt;

`ifdef SWEEP_DWELL_EN
  localparam int unsigned DW_W = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
  logic [DW_W-1:0] r_dwell;
  logic            w_dwell_ld, w_dwell_dec;
`endif

  udcnt_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .load_val (lo),
    .en       (w_en),
    .mode     (w_mode),
    .cnt      (w_cnt)
  );

  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_en      = 1'b0;
    w_mode    = 1'b0;
    w_cap     = 1'b0;
    w_rej     = 1'b0;
    w_rem_dec = 1'b0;
    w_dir_nxt = r_dir;
`ifdef SWEEP_DWELL_EN
    w_dwell_ld  = 1'b0;
    w_dwell_dec = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if ((lo < hi) && (cycles != '0)) begin
            w_cap     = 1'b1;
            w_load    = 1'b1;
            w_dir_nxt = 1'b0;
            w_next    = S_UP;
          end else begin
            w_rej = 1'b1;
          end
        end
      end
      S_UP: begin
        if (abort) begin
          w_next = S_IDLE;
        end else if (w_cnt != r_hi) begin
          w_en = 1'b1;
        end else begin
`ifdef SWEEP_DWELL_EN
          w_dwell_ld = 1'b1;
          w_next     = S_DWELL;
`else
          w_en      = 1'b1;
          w_mode    = 1'b1;
          w_dir_nxt = 1'b1;
          w_next    = S_DOWN;
`endif
        end
      end
      S_DOWN: begin
        if (abort) begin
          w_next = S_IDLE;
        end else if (w_cnt != r_lo) begin
          w_en   = 1'b1;
          w_mode = 1'b1;
        end else if (r_rem == CYC_W'(1)) begin
          w_next = S_DONE;
        end else begin
          w_rem_dec = 1'b1;
`ifdef SWEEP_DWELL_EN
          w_dwell_ld = 1'b1;
          w_next     = S_DWELL;
`else
          w_en      = 1'b1;
          w_dir_nxt = 1'b0;
          w_next    = S_UP;
`endif
        end
      end
`ifdef SWEEP_DWELL_EN
      // dir still holds the pre-turn direction; the exit step reverses it.
      S_DWELL: begin
        if (abort) begin
          w_next = S_IDLE;
        end else if (r_dwell == '0) begin
          w_en      = 1'b1;
          w_mode    = ~r_dir;
          w_dir_nxt = ~r_dir;
          w_next    = r_dir ? S_UP : S_DOWN;
        end else begin
          w_dwell_dec = 1'b1;
        end
      end
`endif
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_lo    <= '0;
      r_hi    <= '0;
      r_rem   <= '0;
      r_dir   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_dir   <= w_dir_nxt;
      r_err   <= w_rej;
      if (w_cap) begin
        r_lo  <= lo;
        r_hi  <= hi;
        r_rem <= cycles;
      end else if (w_rem_dec) begin
        r_rem <= r_rem - 1'b1;
      end
    end
  end

`ifdef SWEEP_DWELL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              r_dwell <= '0;
    else if (w_dwell_ld)  r_dwell <= DW_W'(DWELL_CYC - 1);
    else if (w_dwell_dec) r_dwell <= r_dwell - 1'b1;
  end
`endif

  assign cnt  = w_cnt;
  assign dir  = r_dir;
  assign busy = (r_state == S_UP) || (r_state == S_DOWN) || (r_state == S_DWELL);
  assign done = (r_state == S_DONE);
  assign err  = r_err;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
module tb_updown_sweep_ctrl;

`ifdef SWEEP_DWELL_EN
  localparam int unsigned DWELL = 2;
`else
  localparam int unsigned DWELL = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] lo = '0;
  logic [7:0] hi = '0;
  logic [3:0] cycles = '0;
  logic [7:0] cnt;
  logic       dir, busy, done, err;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  updown_sweep_ctrl #(.WIDTH(8), .CYC_W(4), .DWELL_CYC(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .abort  (abort),
    .lo     (lo),
    .hi     (hi),
    .cycles (cycles),
    .cnt    (cnt),
    .dir    (dir),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: expected (cnt, dir) per cycle from T+1 until the final lo.
  task automatic build_seq(input int l, input int h, input int n,
                           output int cq[$], output int dq[$]);
    cq = {}; dq = {};
    cq.push_back(l); dq.push_back(0);
    for (int r = 0; r < n; r++) begin
      for (int v = l + 1; v <= h; v++) begin cq.push_back(v); dq.push_back(0); end
      for (int k = 0; k < DWELL; k++) begin cq.push_back(h); dq.push_back(0); end
      for (int v = h - 1; v >= l; v--) begin cq.push_back(v); dq.push_back(1); end
      if (r < n - 1)
        for (int k = 0; k < DWELL; k++) begin cq.push_back(l); dq.push_back(1); end
    end
  endtask

  // Full sweep; with noise, inputs and start are scrambled while busy.
  task automatic run_sweep(input int l, input int h, input int n, input bit noise);
    int cq[$];
    int dq[$];
    build_seq(l, h, n, cq, dq);
    lo = 8'(l); hi = 8'(h); cycles = 4'(n); start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < cq.size(); i++) begin
      chk("sweep_cnt", 32'(cnt), 32'(cq[i]));
      chk("sweep_dir", 32'(dir), 32'(dq[i]));
      chk("sweep_busy", 32'(busy), 32'd1);
      chk("sweep_done_low", 32'(done), 32'd0);
      if (noise) begin
        lo = 8'($urandom); hi = 8'($urandom); cycles = 4'($urandom);
        start = 1'($urandom);
      end
      tick();
    end
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_cnt", 32'(cnt), 32'(l));
    start = 1'b0;
    tick();
    chk("done_end", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_cnt", 32'(cnt), 32'(l));
  endtask

  initial begin
    int rl, rh, rn;
    int cq[$];
    int dq[$];
    logic [7:0] held;

    #12;
    chk("rst_cnt", 32'(cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dir", 32'(dir), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    tick();

    // directed triangle 3..5, two round trips
    run_sweep(3, 5, 2, 1'b0);

    // rejected starts: lo == hi, then cycles == 0
    held = cnt;
    lo = 8'd5; hi = 8'd5; cycles = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    chk("err_eq", 32'(err), 32'd1);
    chk("err_eq_busy", 32'(busy), 32'd0);
    chk("err_eq_cnt", 32'(cnt), 32'(held));
    tick();
    chk("err_eq_end", 32'(err), 32'd0);
    lo = 8'd1; hi = 8'd9; cycles = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("err_cyc0", 32'(err), 32'd1);
    chk("err_cyc0_busy", 32'(busy), 32'd0);
    chk("err_cyc0_cnt", 32'(cnt), 32'(held));
    tick();
    chk("err_cyc0_end", 32'(err), 32'd0);

    // abort in IDLE has no effect
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle_busy", 32'(busy), 32'd0);
    chk("abort_idle_cnt", 32'(cnt), 32'(held));

    // full range, single round trip
    run_sweep(0, 255, 1, 1'b0);

    // abort on the first down leg at cnt = 14
    build_seq(10, 20, 3, cq, dq);
    lo = 8'd10; hi = 8'd20; cycles = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    chk("pre_abort_cnt", 32'(cnt), 32'(cq[16]));
    chk("pre_abort_dir", 32'(dir), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_cnt", 32'(cnt), 32'd14);
    for (int i = 0; i < 4; i++) begin
      chk("abort_no_done", 32'(done), 32'd0);
      tick();
    end
    chk("abort_hold_cnt", 32'(cnt), 32'd14);

    // new start accepted after abort, with scrambled inputs while busy
    run_sweep(3, 5, 2, 1'b1);

    // randomized sweeps with input noise
    for (int k = 0; k < 8; k++) begin
      rl = int'($urandom_range(0, 240));
      rh = rl + 1 + int'($urandom_range(0, 12));
      rn = int'($urandom_range(1, 3));
      run_sweep(rl, rh, rn, 1'b1);
    end

    // asynchronous reset mid-sweep
    lo = 8'd40; hi = 8'd60; cycles = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 25; i++) tick();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    chk("pre_rst_dir", 32'(dir), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_cnt", 32'(cnt), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_dir", 32'(dir), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_busy", 32'(busy), 32'd0);

    // dwell pattern case (plain triangle when the feature is off)
    run_sweep(1, 3, 2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
